fifo_stream_reader: RTL
=======================

// Module: fifo_stream_reader
// PURPOSE
//  Downstream pop stage for the dual-port-RAM circular FIFO. Drives the FIFO's read strobe, absorbs the
//  RAM's registered read latency and presents words on a valid/ready stream to the consumer (display/UART).
//  A small output skid buffer sustains one word per clock with ready held high; consumer back-pressure is
//  never allowed to lose a word or over-read the FIFO.
// PARAMETERS
//  width        8  bits per word; must equal the FIFO's width
//  READ_LAT     1  cycles from read asserted (posedge N) to word valid on rdData (posedge N+READ_LAT); 1..3
//  BUF_DEPTH    READ_LAT+1  skid-buffer entries; must be >= READ_LAT+1
// PORTS
//  clk       in   1            single clock, all state on posedge
//  reset     in   1            synchronous, active-high
//  empty     in   1            FIFO empty flag
//  rdData    in   width        FIFO outputBus
//  read      out  1            pop strobe to FIFO; one word per cycle asserted
//  outData   out  width        head word of skid buffer
//  outValid  out  1            outData holds a valid word
//  outReady  in   1            consumer accepts when outValid && outReady at posedge
//  popCount  out  16           [FIFO_READER_CNT_EN only] words delivered to consumer
// BEHAVIOUR
//  Reset (sync, active-high): read=0, outValid=0, outData=0, popCount=0, occupancy=0, in-flight pipe cleared.
//  read is combinational: read = !reset && !empty && (occ + inflight - accept) < BUF_DEPTH,
//   where accept = outValid && outReady this cycle; it never asserts while empty=1.
//  In-flight tracker: READ_LAT-deep shift register of valid bits, fed by read. Bit exiting at cycle
//   N+READ_LAT captures rdData into buffer tail in that cycle.
//  Skid buffer: circular, BUF_DEPTH entries, head/tail pointers wrap modulo BUF_DEPTH, occupancy 0..BUF_DEPTH.
//   outValid = (occ != 0); outData = buffer[head] (0 when occ==0).
//  Simultaneous capture and accept: occ unchanged, both pointers advance; with occ==BUF_DEPTH
//   the accepted slot is not overwritten (capture goes to tail, head advances).
//  Occupancy + inflight never exceeds BUF_DEPTH; a capture into a full buffer is a design error
//   (assertion in bench).
//  Back-pressure: outReady=0 -> outData/outValid held stable; read deasserts once occ+inflight==BUF_DEPTH.
//  Throughput: outReady held 1 and FIFO non-empty -> one word per cycle after READ_LAT+1 cycle startup.
//  First word latency: empty falls at cycle N -> read at N, outValid at N+READ_LAT+1.
//  empty rising mid-burst: read drops same cycle; words already in flight still captured and delivered.
//  Reset mid-operation: in-flight words and buffered words discarded; no read issued during reset cycle.
//  Ordering: words leave in exactly the order popped from the FIFO.
// CONFIGURATION
//  FIFO_READER_CNT_EN defined: popCount port exists; increments by 1 on each accept, wraps 16'hFFFF->0,
//   cleared by reset.
//  FIFO_READER_CNT_EN undefined: popCount port and counter absent; all other behaviour identical.
// TESTING  (READ_LAT=1, BUF_DEPTH=2, width=8 unless stated)
//  Reset: reset=1 two cycles with empty=0 -> read=0, outValid=0, outData=8'h00 throughout.
//  Single word: FIFO holds 8'h01, outReady=1 -> one read pulse, outValid 1 cycle with 8'h01, empty then read=0.
//  Burst: FIFO preloaded 8'h01..8'h05, outReady=1 -> 5 consecutive read cycles, outData 01..05 back-to-back.
//  Back-pressure: preload 01..04, outReady=0 -> exactly 2 reads, outData=01 stable; outReady=1 -> 01,02,03,04
//   in order, no loss or duplicate.
//  Reset mid-burst: preload 01..05, reset at 3rd delivered word -> outValid=0 next cycle, no read in reset cycle.
//  Counter (FIFO_READER_CNT_EN): deliver 5 words -> popCount=5; reset -> popCount=0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Pop stage for the dual-port-RAM FIFO: drives the read strobe, absorbs the RAM read latency and
// streams words through a skid buffer onto valid/ready. Optional FIFO_READER_CNT_EN adds popCount.
module fifo_stream_reader #(
  parameter int DATA_W    = 8,
  parameter int READ_LAT  = 1,
  parameter int BUF_DEPTH = READ_LAT + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty,
  input  logic [DATA_W-1:0] rdData,
  output logic              read,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
`ifdef FIFO_READER_CNT_EN
  input  logic              outReady,
  output logic [15:0]       popCount
`else
  input  logic              outReady
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int LVL_W = OCC_W + 3;

  logic [READ_LAT-1:0] vld_p;
  logic [DATA_W-1:0]   skid_mem [BUF_DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [OCC_W-1:0]    occ;
  logic [2:0]          inflight;
  logic [LVL_W-1:0]    level;
  logic                capture;
  logic                accept;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign capture  = vld_p[READ_LAT-1];
  assign outValid = (occ != '0);
  assign accept   = outValid && outReady;

  // Issue: a read is allowed only if the word it returns is guaranteed a free slot
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) inflight = inflight + {2'b00, vld_p[i]};
    level = LVL_W'(occ) + LVL_W'(inflight) - LVL_W'(accept);
    read  = !reset && !empty && (level < LVL_W'(BUF_DEPTH));
  end

  always_comb begin
    outData = '0;
    if (occ != '0) outData = skid_mem[head];
  end

  // In-flight tracker and skid-buffer control
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
      head  <= '0;
      tail  <= '0;
      occ   <= '0;
    end else begin
      vld_p[0] <= read;
      for (int i = 1; i < READ_LAT; i++) vld_p[i] <= vld_p[i-1];
      if (capture) tail <= ptr_inc(tail);
      if (accept)  head <= ptr_inc(head);
      if (capture && !accept)      occ <= occ + OCC_W'(1);
      else if (!capture && accept) occ <= occ - OCC_W'(1);
    end
  end

  // Capture stage: the word returned by the RAM lands at the tail
  always_ff @(posedge clk) begin
    if (capture) skid_mem[tail] <= rdData;
  end

`ifdef FIFO_READER_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)       popCount <= '0;
    else if (accept) popCount <= popCount + 16'd1;
  end
`endif

endmodule
